mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_WORDS, default 1024, number of 32-bit RAM words (power of two).
REQ-002 Parameter CLKS_PER_BIT, default 104, UART bit period in clk cycles (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_addr  input  32  byte address from processor.
REQ-006 mem_rstrb  input  1  read request, one-cycle pulse.
REQ-007 mem_wdata  input  32  write data.
REQ-008 mem_wmask  input  4  byte write enables; nonzero = write request.
REQ-009 mem_rdata  output  32  registered read data.
REQ-010 LEDS  output  5  LED register.
REQ-011 TXD  output  1  UART serial output, 8N1, idle high.

Function
REQ-012 mem_addr[22]=0 selects RAM; mem_addr[22]=1 selects IO page; all other upper bits ignored.
REQ-013 RAM word index = mem_addr[log2(RAM_WORDS)+1:2]; higher bits ignored, so addresses wrap modulo RAM size.
REQ-014 Read latency exactly 1 cycle: mem_rstrb high at edge N -> mem_rdata valid after edge N, held until the next mem_rstrb.
REQ-015 RAM write: each byte lane i with mem_wmask[i]=1 updates bits [8i+7:8i] at the edge; other lanes unchanged.
REQ-016 Simultaneous mem_rstrb and write to the same word: mem_rdata returns the pre-write content.
REQ-017 IO offset mem_addr[3:2]=0 LEDS: write (mem_wmask[0]=1) loads mem_wdata[4:0]; read returns {27'b0, LEDS}.
REQ-018 IO offset 1 UART_DATA: write (any mem_wmask bit) while not busy starts transmission of mem_wdata[7:0]; write while busy is dropped; read returns 0.
REQ-019 IO offset 2 UART_STATUS: read returns {31'b0, busy}; writes ignored.
REQ-020 IO offset 3: reads return 0; writes ignored.
REQ-021 UART states IDLE, START, DATA, STOP; IDLE->START on accepted write; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits of CLKS_PER_BIT cycles each, LSB first; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-022 TXD is registered: low from the cycle after the accepted write; high in IDLE and STOP.
REQ-023 busy = 1 in every state except IDLE; a frame lasts exactly 10*CLKS_PER_BIT cycles.
REQ-024 A write to UART_DATA on the same cycle STOP returns to IDLE is dropped (busy still 1 at that edge).

Reset
REQ-025 On reset assertion, immediately: mem_rdata=0, LEDS=0, TXD=1, UART state IDLE, busy=0, bit and baud counters 0.
REQ-026 Reset mid-frame aborts the frame with no further TXD transitions; RAM contents are not cleared.

Configuration
REQ-027 Macro UART_TX_EN defined: UART per REQ-018..REQ-024.
REQ-028 Macro UART_TX_EN undefined: no UART logic; TXD constant 1; UART_DATA writes ignored; UART_STATUS reads 0.

Verification
REQ-029 Write 0xDEADBEEF mask 4'b1111 to 0x10, then mask 4'b0010 data 0x00005500 -> read 0x10 returns 0xDEAD55EF one cycle after mem_rstrb.
REQ-030 RAM_WORDS=1024: write 0x12345678 to 0x1000 -> read 0x0 returns 0x12345678 (wrap).
REQ-031 Write 0x1F to 0x400000 -> LEDS=5'b11111; read 0x400000 returns 0x0000001F.
REQ-032 CLKS_PER_BIT=4, write 0xA5 to 0x400004 -> TXD sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles; status reads 1 during frame, 0 after 40 cycles.
REQ-033 Write 0x3C to UART_DATA while busy -> frame in progress unchanged, 0x3C never transmitted.
REQ-034 Assert reset at bit 3 of a frame -> TXD=1, LEDS=0, status 0 immediately; RAM word previously written still reads back unchanged.

Source files
------------

// File: rtl/mem_io_responder.sv
// Processor-side memory/IO responder: byte-maskable RAM plus an IO page holding an
// LED register and an 8N1 UART transmitter (built only when UART_TX_EN is defined).
module mem_io_responder #(
    parameter int RAM_WORDS    = 1024,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] mem_rdata,
    output logic [4:0]  LEDS,
    output logic        TXD
);
    localparam int         AW             = $clog2(RAM_WORDS);
    localparam logic [1:0] IO_LEDS        = 2'd0;
    localparam logic [1:0] IO_UART_DATA   = 2'd1;
    localparam logic [1:0] IO_UART_STATUS = 2'd2;

    logic          is_io;
    logic [1:0]    io_off;
    logic [AW-1:0] word_idx;
    logic          busy;
    logic          unused_addr;

    // Only bit 22, the word offset and the RAM index bits decode; the rest alias.
    assign is_io       = mem_addr[22];
    assign io_off      = mem_addr[3:2];
    assign word_idx    = mem_addr[AW+1:2];
    assign unused_addr = ^mem_addr;

    // ------------------------------------------------------------------ RAM
    logic [31:0] ram_q [RAM_WORDS];

    // NOTE: the RAM array has no reset so it maps onto block/distributed RAM;
    // its contents also have to survive a reset.
    always_ff @(posedge clk) begin
        if (!is_io) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask[i]) begin
                    ram_q[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------ LEDs
    logic [4:0] leds_q, leds_d;

    // NOTE: every always_comb output gets its hold value first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        leds_d = leds_q;
        if (is_io && (io_off == IO_LEDS) && mem_wmask[0]) begin
            leds_d = mem_wdata[4:0];
        end
    end

    // ------------------------------------------------------------- read data
    logic [31:0] rdata_q, rdata_d;

    // The RAM is read combinationally here and captured at the edge, so a
    // same-cycle write to that word is seen only by the next read.
    always_comb begin
        rdata_d = rdata_q;
        if (mem_rstrb) begin
            if (!is_io) begin
                rdata_d = ram_q[word_idx];
            end else begin
                case (io_off)
                    IO_LEDS:        rdata_d = {27'b0, leds_q};
                    IO_UART_STATUS: rdata_d = {31'b0, busy};
                    default:        rdata_d = '0;
                endcase
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            leds_q  <= '0;
        end else begin
            rdata_q <= rdata_d;
            leds_q  <= leds_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign LEDS      = leds_q;

    // ------------------------------------------------------------------ UART
`ifdef UART_TX_EN
    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          uart_wr;
    logic          baud_done;

    assign busy      = (state_q != IDLE);
    assign uart_wr   = is_io && (io_off == IO_UART_DATA) && (|mem_wmask) && !busy;
    assign baud_done = (baud_q == BAUD_LAST);

    // txd_d is the line level for the period that starts at the coming edge,
    // which keeps TXD a clean registered output.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (uart_wr) begin
                    state_d = START;
                    shift_d = mem_wdata[7:0];
                    baud_d  = '0;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (baud_done) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign TXD = txd_q;
`else
    assign busy = 1'b0;
    assign TXD  = 1'b1;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboarded bench for mem_io_responder: reads push expected data into a queue
// that a monitor drains; LED and TXD levels are checked directly per cycle.
module tb_mem_io_responder;
    localparam int CPB = 4;
`ifdef UART_TX_EN
    localparam bit UART_ON = 1'b1;
`else
    localparam bit UART_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic [31:0] mem_rdata;
    logic [4:0]  LEDS;
    logic        TXD;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    mem_io_responder #(
        .RAM_WORDS   (1024),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_addr (mem_addr),
        .mem_rstrb(mem_rstrb),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata),
        .LEDS     (LEDS),
        .TXD      (TXD)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: a strobe sampled at a rising edge means read data is due by the next falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (mem_rstrb && !reset) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rdata_unexpected: got %h want nothing queued", mem_rdata);
                end else begin
                    check("rdata", mem_rdata, exp_q.pop_front());
                end
            end
        end
    end

    // All stimulus tasks are entered at a falling edge and return at the next one.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_rstrb = 1'b0;
            mem_wmask = '0;
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        mem_rstrb = 1'b0;
        @(negedge clk);
        mem_wmask = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        mem_wmask = '0;
        exp_q.push_back(e);
        @(negedge clk);
        mem_rstrb = 1'b0;
    endtask

    // Sends one byte and checks TXD every cycle for 48 cycles; a second UART_DATA
    // write is attempted at cycle drop_i and status is polled around the frame end.
    task automatic frame(input logic [7:0] data, input int drop_i, input logic [7:0] drop_data,
                         input string tag);
        logic [9:0] bits;
        logic       exp_txd;
        bits = {1'b1, data, 1'b0};
        wr(32'h0040_0004, {24'h0, data}, 4'b0001);
        for (int i = 0; i < 48; i++) begin
            mem_rstrb = 1'b0;
            mem_wmask = '0;
            if (i == drop_i) begin
                mem_addr  = 32'h0040_0004;
                mem_wdata = {24'h0, drop_data};
                mem_wmask = 4'b0010;
            end else if (i == 5 || i == 38 || i == 39 || i == 40 || i == 44) begin
                mem_addr  = 32'h0040_0008;
                mem_rstrb = 1'b1;
                exp_q.push_back({31'b0, UART_ON && (i < 40)});
            end
            exp_txd = (UART_ON && (i < 40)) ? bits[i/4] : 1'b1;
            check($sformatf("%s_txd_c%0d", tag, i), {31'b0, TXD}, {31'b0, exp_txd});
            @(negedge clk);
        end
        mem_rstrb = 1'b0;
        mem_wmask = '0;
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_leds", {27'b0, LEDS}, 32'h0);
        check("reset_txd", {31'b0, TXD}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        // Byte lanes
        wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h10, 32'h0000_5500, 4'b0010);
        rd(32'h10, 32'hDEAD_55EF);
        idle(3);
        check("rdata_hold", mem_rdata, 32'hDEAD_55EF);
        wr(32'h14, 32'h1122_3344, 4'b1111);
        wr(32'h14, 32'hAB00_0000, 4'b1000);
        rd(32'h14, 32'hAB22_3344);
        wr(32'h18, 32'h0000_0000, 4'b1111);
        wr(32'h18, 32'hFFFF_FFFF, 4'b0101);
        rd(32'h18, 32'h00FF_00FF);

        // Address wrap and ignored upper bits
        wr(32'h1000, 32'h1234_5678, 4'b1111);
        rd(32'h0, 32'h1234_5678);
        rd(32'h0080_1000, 32'h1234_5678);
        wr(32'hFFC, 32'hCAFE_F00D, 4'b1111);
        rd(32'h3FFC, 32'hCAFE_F00D);

        // Read and write of the same word in one cycle returns the old content
        wr(32'h20, 32'h0101_0101, 4'b1111);
        mem_addr  = 32'h20;
        mem_wdata = 32'h0202_0202;
        mem_wmask = 4'b1111;
        mem_rstrb = 1'b1;
        exp_q.push_back(32'h0101_0101);
        @(negedge clk);
        idle(1);
        rd(32'h20, 32'h0202_0202);

        // LED register
        wr(32'h0040_0000, 32'h0000_001F, 4'b0001);
        check("leds_load", {27'b0, LEDS}, 32'h1F);
        rd(32'h0040_0000, 32'h0000_001F);
        wr(32'h0040_0000, 32'h0000_0000, 4'b1110);
        check("leds_lane0_only", {27'b0, LEDS}, 32'h1F);
        wr(32'h7F40_0010, 32'hFFFF_FFE5, 4'b0001);
        check("leds_alias", {27'b0, LEDS}, 32'h05);
        rd(32'h0040_0000, 32'h0000_0005);
        rd(32'h0, 32'h1234_5678);

        // Unused IO offsets and UART read-backs while idle
        wr(32'h0040_000C, 32'hFFFF_FFFF, 4'b1111);
        wr(32'h0040_0008, 32'hFFFF_FFFF, 4'b1111);
        check("leds_after_io_writes", {27'b0, LEDS}, 32'h05);
        rd(32'h0040_000C, 32'h0);
        rd(32'h0040_0004, 32'h0);
        rd(32'h0040_0008, 32'h0);

        // UART frames: a write mid-frame, then one on the STOP->IDLE edge, are dropped
        frame(8'hA5, 10, 8'h3C, "frame_a5");
        frame(8'h81, 39, 8'h00, "frame_81");

        // Reset during data bit 3 (data 0x52: bit 3 is 0, so TXD is low before reset)
        rd(32'h10, 32'hDEAD_55EF);
        wr(32'h0040_0000, 32'h0000_0015, 4'b0001);
        wr(32'h0040_0004, 32'h0000_0052, 4'b0001);
        idle(17);
        check("pre_reset_txd", {31'b0, TXD}, {31'b0, !UART_ON});
        #1 reset = 1'b1;
        #1;
        check("midreset_txd", {31'b0, TXD}, 32'h1);
        check("midreset_leds", {27'b0, LEDS}, 32'h0);
        check("midreset_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("post_reset_txd_c%0d", i), {31'b0, TXD}, 32'h1);
            @(negedge clk);
        end
        rd(32'h0040_0008, 32'h0);
        rd(32'h10, 32'hDEAD_55EF);
        rd(32'h0040_0000, 32'h0);

        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
